fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
Parametrised ping-pong reorder buffer placed between the FFT compute core and the write DMA path. It accepts FFT output samples in natural arrival order and emits each frame in bit-reversed order, or in natural order when bypass is selected. Point size is selectable per frame at run time. Two banks let one frame fill while the previous frame drains, so streaming runs at full rate. It adds an explicit frame-last flag and a frame-done pulse for the top decoder and interrupt logic.

Parameters:
DATA_WIDTH, 64, width of one complex sample (packed real/imag).
MAX_LOG2_POINT, 10, log2 of largest supported FFT size; each bank holds 2^MAX_LOG2_POINT entries.
MIN_LOG2_POINT, 3, log2 of smallest supported FFT size.
LW, $clog2(MAX_LOG2_POINT+1), width of the point-size config field.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
cfg_log2_point  in  LW  log2 FFT size for the next frame.
cfg_bypass  in  1  1 = emit the frame in natural order.
in_valid  in  1  input sample valid.
in_data  in  DATA_WIDTH  input sample.
in_ready  out  1  buffer can accept a sample.
out_valid  out  1  output sample valid.
out_data  out  DATA_WIDTH  output sample.
out_last  out  1  marks the final sample of a frame; qualified by out_valid.
out_ready  in  1  downstream accepts the sample.
frame_done  out  1  one-cycle pulse when the last sample of a frame is accepted at the output.
busy  out  1  any bank non-EMPTY or out_valid high.

Behaviour:
- Reset (async assert):
  - both banks EMPTY; write and read bank pointers = 0; counters = 0.
  - out_valid = 0, out_last = 0, out_data = 0, frame_done = 0, busy = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - Memory contents are don't-care.
  - Reset mid-frame discards all partial and full frames.
- Bank states: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Config latch:
  - On the first accepted input of a frame (write bank EMPTY), cfg_log2_point and cfg_bypass are captured into that bank's private config.
  - Config changes mid-frame have no effect until the next frame.
  - cfg_log2_point is clamped to [MIN_LOG2_POINT, MAX_LOG2_POINT].
- Write side:
  - Input handshake = in_valid & in_ready.
  - in_ready = 1 when the write bank is EMPTY or FILLING.
  - Sample k is written to address bitrev_L(k), where L is the latched log2 point and the reversal covers only the low L bits. In bypass, address = k.
  - When k = 2^L - 1 is written, the bank goes FULL, the write pointer toggles, and k resets to 0.
- Read side:
  - The read bank is read sequentially, addresses 0 .. 2^L-1, into a single output register.
  - The register loads when (!out_valid | out_ready) and the read bank is FULL or DRAINING.
  - A FULL bank goes DRAINING on its first load.
  - When address 2^L-1 is loaded, out_last is set with that sample, the bank goes EMPTY, and the read pointer toggles.
  - out_valid/out_data/out_last are held stable while out_valid & !out_ready.
- Latency:
  - Last input handshake at edge k makes the bank FULL.
  - Entry 0 loads at edge k+1, so out_valid is high in the cycle after edge k+1.
- Throughput:
  - With out_ready = 1 continuously, frames of equal size stream with no input stall.
  - The write bank becomes FULL only while the other bank drains. in_ready drops only when both banks are FULL or DRAINING.
- Simultaneous events:
  - A bank freed by the final read load may accept a write in the following cycle, not the same cycle. No same-cycle read/write to one bank.
  - A write into one bank and a read from the other in the same cycle is always allowed.
- frame_done = out_valid & out_ready & out_last, registered, so it pulses 1 cycle after the last output handshake.
- busy is combinational from bank states and out_valid.

Test Plan:
- N=8 (cfg_log2_point=3), inputs 0..7 with out_ready=1 -> outputs 0,4,2,6,1,5,3,7; out_last only on 7; frame_done pulses once, 1 cycle after.
- cfg_bypass=1, N=16, inputs 0..15 -> outputs 0..15 in order; out_last on 15; first out_valid 2 edges after the last input handshake.
- Three back-to-back N=8 frames, in_valid=1, out_ready=1 -> in_ready never deasserts; 24 outputs in bit-reversed order per frame; 3 frame_done pulses.
- out_ready=0, stream N=8 frames -> in_ready falls after 16 accepted samples; out_data holds value 0 stable; releasing out_ready drains 16 samples in order.
- cfg_log2_point changed from 3 to 4 after sample 3 of a frame -> that frame still ends after 8 samples; the next frame uses N=16. cfg_log2_point=15 -> clamped to MAX (1024 samples).
- rst asserted after 5 samples of an N=8 frame, with the other bank DRAINING -> outputs immediately 0, busy=0, in_ready=1 after release; the next frame reorders correctly from sample 0.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer between the FFT core and the write DMA path.
// Samples arrive in natural order and are written at bit-reversed addresses
// (or linear addresses in bypass), then read out sequentially so each frame
// leaves in bit-reversed order. One bank fills while the other drains.
//
// state    | meaning
// ---------+------------------------------------------------------------
// EMPTY    | bank free; next accepted sample starts a frame, latches cfg
// FILLING  | bank accepting samples of the current frame
// FULL     | frame complete, waiting for the output register
// DRAINING | frame being read out sequentially
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH     = 64,
    parameter int MAX_LOG2_POINT = 10,
    parameter int MIN_LOG2_POINT = 3,
    parameter int LW             = $clog2(MAX_LOG2_POINT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LW-1:0]         cfg_log2_point,
    input  logic                  cfg_bypass,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int AW    = MAX_LOG2_POINT;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t           state_q [2];
    bank_state_t           state_d [2];
    logic [LW-1:0]         bank_l_q [2];
    logic                  bank_byp_q [2];
    logic                  wr_sel, rd_sel;
    logic [AW-1:0]         wr_cnt, rd_cnt;
    logic [DATA_WIDTH-1:0] mem0 [DEPTH];
    logic [DATA_WIDTH-1:0] mem1 [DEPTH];

    logic                  wr_empty, wr_fire, wr_last, wr_byp;
    logic [LW-1:0]         wr_l;
    logic [AW-1:0]         wr_addr;
    logic                  rd_load, rd_last;
    logic [DATA_WIDTH-1:0] rd_data;

    function automatic logic [LW-1:0] clamp_l(input logic [LW-1:0] l);
        if (l < LW'(MIN_LOG2_POINT)) return LW'(MIN_LOG2_POINT);
        if (l > LW'(MAX_LOG2_POINT)) return LW'(MAX_LOG2_POINT);
        return l;
    endfunction

    function automatic logic [AW-1:0] last_idx(input logic [LW-1:0] l);
        logic [AW:0] span;
        span = (AW + 1)'(1) << l;
        return AW'(span - (AW + 1)'(1));
    endfunction

    // Reverse the full counter, then shift down so only the low l bits are mirrored.
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] k, input logic [LW-1:0] l);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = k[AW-1-i];
        return r >> (LW'(AW) - l);
    endfunction

    // Write side: handshake, address generation and end-of-frame detect.
    // A fresh frame uses the live config; later samples use the bank's latched copy.
    always_comb begin
        wr_empty = (state_q[wr_sel] == EMPTY);
        in_ready = wr_empty || (state_q[wr_sel] == FILLING);
        wr_fire  = in_valid && in_ready;
        wr_l     = wr_empty ? clamp_l(cfg_log2_point) : bank_l_q[wr_sel];
        wr_byp   = wr_empty ? cfg_bypass : bank_byp_q[wr_sel];
        wr_addr  = wr_byp ? wr_cnt : bitrev(wr_cnt, wr_l);
        wr_last  = (wr_cnt == last_idx(wr_l));
    end

    // Read side: load the output register whenever it is free or being consumed.
    always_comb begin
        rd_load = (!out_valid || out_ready) &&
                  (state_q[rd_sel] == FULL || state_q[rd_sel] == DRAINING);
        rd_last = (rd_cnt == last_idx(bank_l_q[rd_sel]));
        rd_data = rd_sel ? mem1[rd_cnt] : mem0[rd_cnt];
    end

    // Bank next-state; the write and read banks are never the same bank when both act.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        if (wr_fire) state_d[wr_sel] = wr_last ? FULL : FILLING;
        if (rd_load) state_d[rd_sel] = rd_last ? EMPTY : DRAINING;
    end

    // Bank states, pointers, counters and per-bank frame config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b]    <= EMPTY;
                bank_l_q[b]   <= LW'(MIN_LOG2_POINT);
                bank_byp_q[b] <= 1'b0;
            end
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            if (wr_fire) begin
                if (wr_empty) begin
                    bank_l_q[wr_sel]   <= wr_l;
                    bank_byp_q[wr_sel] <= wr_byp;
                end
                if (wr_last) begin
                    wr_cnt <= '0;
                    wr_sel <= ~wr_sel;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (rd_load) begin
                if (rd_last) begin
                    rd_cnt <= '0;
                    rd_sel <= ~rd_sel;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

    // Sample storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_fire && !wr_sel) mem0[wr_addr] <= in_data;
        if (wr_fire && wr_sel)  mem1[wr_addr] <= in_data;
    end

    // Output register and frame-done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_last;
            if (rd_load) begin
                out_valid <= 1'b1;
                out_data  <= rd_data;
                out_last  <= rd_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Activity flag for the top-level decoder.
    always_comb begin
        busy = (state_q[0] != EMPTY) || (state_q[1] != EMPTY) || out_valid;
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: reorder patterns, bypass, streaming,
// back-pressure, config latching/clamping and mid-frame reset.
module tb_fft_bitrev_reorder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cfg_log2_point;
    logic        cfg_bypass;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        frame_done;
    logic        busy;

    fft_bitrev_reorder dut (
        .clk(clk), .rst(rst),
        .cfg_log2_point(cfg_log2_point), .cfg_bypass(cfg_bypass),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int br8  [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    int br16 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    // monitor state
    int          cyc = 0;
    logic [63:0] out_q [$];
    bit          last_q [$];
    int          in_cnt, stall_cnt, fd_cnt, fd_cyc, last_in_cyc, last_out_cyc, ov_rise_cyc;
    bit          prev_ov = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin in_cnt++; last_in_cyc = cyc; end
            if (in_valid && !in_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                last_q.push_back(out_last);
                last_out_cyc = cyc;
            end
            if (out_valid && !prev_ov) ov_rise_cyc = cyc;
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        end
        prev_ov = out_valid;
    end

    function automatic int bitrev10(input int k);
        int r = 0;
        for (int i = 0; i < 10; i++) if (k & (1 << i)) r |= 1 << (9 - i);
        return r;
    endfunction

    task automatic clear_mon();
        out_q.delete();
        last_q.delete();
        in_cnt = 0; stall_cnt = 0; fd_cnt = 0; fd_cyc = -1;
        last_in_cyc = -1; last_out_cyc = -1; ov_rise_cyc = -1;
    endtask

    // Offer one sample and hold it until accepted; returns at posedge+1.
    task automatic push(input int d);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = 64'(d);
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_fail++;
            $display("FAIL push_timeout: sample %0d not accepted, in_ready=%0b", d, in_ready);
        end
    endtask

    task automatic wait_outs(input int n);
        for (int i = 0; i < 5000 && out_q.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (out_q.size() != n) begin
            n_fail++;
            $display("FAIL out_count: got %0d samples expected %0d", out_q.size(), n);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%0b busy=%0b out_valid=%0b expected 1 0 0",
                     in_ready, busy, out_valid);
        end
        n_checks++;
        if (out_data !== 64'd0 || out_last !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: data=%0h last=%0b done=%0b expected 0 0 0",
                     out_data, out_last, frame_done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bitrev8();
        clear_mon();
        cfg_log2_point = 4'd3; cfg_bypass = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) push(k);
        wait_outs(8);
        for (int j = 0; j < 8 && j < out_q.size(); j++) begin
            n_checks++;
            if (out_q[j] !== 64'(br8[j]) || last_q[j] !== (j == 7)) begin
                n_fail++;
                $display("FAIL bitrev8[%0d]: got %0d last=%0b expected %0d last=%0b",
                         j, out_q[j], last_q[j], br8[j], (j == 7));
            end
        end
        n_checks++;
        if (fd_cnt != 1 || fd_cyc - last_out_cyc != 1) begin
            n_fail++;
            $display("FAIL bitrev8_done: pulses=%0d delay=%0d expected 1 1", fd_cnt, fd_cyc - last_out_cyc);
        end
        wait_idle();
    endtask

    task automatic test_bypass16();
        clear_mon();
        cfg_log2_point = 4'd4; cfg_bypass = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 16; k++) push(100 + k);
        cfg_bypass = 1'b0;
        wait_outs(16);
        for (int j = 0; j < 16 && j < out_q.size(); j++) begin
            n_checks++;
            if (out_q[j] !== 64'(100 + j) || last_q[j] !== (j == 15)) begin
                n_fail++;
                $display("FAIL bypass16[%0d]: got %0d last=%0b expected %0d last=%0b",
                         j, out_q[j], last_q[j], 100 + j, (j == 15));
            end
        end
        n_checks++;
        if (ov_rise_cyc - last_in_cyc != 2) begin
            n_fail++;
            $display("FAIL bypass16_latency: got %0d edges expected 2", ov_rise_cyc - last_in_cyc);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        clear_mon();
        cfg_log2_point = 4'd3; cfg_bypass = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 24; k++) push(200 + k);
        wait_outs(24);
        n_checks++;
        if (stall_cnt != 0) begin
            n_fail++;
            $display("FAIL b2b_stall: got %0d stalled cycles expected 0", stall_cnt);
        end
        for (int j = 0; j < 24 && j < out_q.size(); j++) begin
            n_checks++;
            if (out_q[j] !== 64'(200 + (j / 8) * 8 + br8[j % 8]) || last_q[j] !== (j % 8 == 7)) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %0d expected %0d", j, out_q[j], 200 + (j / 8) * 8 + br8[j % 8]);
            end
        end
        n_checks++;
        if (fd_cnt != 3) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d pulses expected 3", fd_cnt);
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        clear_mon();
        cfg_log2_point = 4'd3; cfg_bypass = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 16; k++) push(k);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 64'd0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: in_ready=%0b out_valid=%0b data=%0d expected 0 1 0",
                         c, in_ready, out_valid, out_data);
            end
        end
        n_checks++;
        if (in_cnt != 16) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d expected 16", in_cnt);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_outs(16);
        for (int j = 0; j < 16 && j < out_q.size(); j++) begin
            n_checks++;
            if (out_q[j] !== 64'((j / 8) * 8 + br8[j % 8])) begin
                n_fail++;
                $display("FAIL bp_drain[%0d]: got %0d expected %0d", j, out_q[j], (j / 8) * 8 + br8[j % 8]);
            end
        end
        wait_idle();
    endtask

    task automatic test_cfg_latch();
        int nl;
        clear_mon();
        cfg_log2_point = 4'd3; cfg_bypass = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) push(300 + k);
        cfg_log2_point = 4'd4;
        for (int k = 4; k < 8; k++) push(300 + k);
        for (int k = 0; k < 16; k++) push(400 + k);
        wait_outs(24);
        for (int j = 0; j < 24 && j < out_q.size(); j++) begin
            int e;
            e = (j < 8) ? 300 + br8[j] : 400 + br16[j - 8];
            n_checks++;
            if (out_q[j] !== 64'(e)) begin
                n_fail++;
                $display("FAIL cfg_latch[%0d]: got %0d expected %0d", j, out_q[j], e);
            end
        end
        nl = 0;
        foreach (last_q[j]) if (last_q[j]) nl++;
        n_checks++;
        if (nl != 2 || last_q.size() != 24 || !last_q[7] || !last_q[23]) begin
            n_fail++;
            $display("FAIL cfg_latch_last: got %0d last flags expected 2 at 7 and 23", nl);
        end
        wait_idle();
    endtask

    task automatic test_clamp();
        int bad, nl;
        clear_mon();
        cfg_log2_point = 4'd15; cfg_bypass = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 1024; k++) push(k);
        cfg_log2_point = 4'd3;
        wait_outs(1024);
        bad = 0; nl = 0;
        for (int j = 0; j < out_q.size(); j++) begin
            if (out_q[j] !== 64'(bitrev10(j))) bad++;
            if (last_q[j]) nl++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL clamp_order: got %0d wrong samples expected 0", bad);
        end
        n_checks++;
        if (nl != 1 || last_q.size() != 1024 || !last_q[1023] || fd_cnt != 1) begin
            n_fail++;
            $display("FAIL clamp_last: got %0d last flags, %0d pulses expected 1 1", nl, fd_cnt);
        end
        wait_idle();
    endtask

    task automatic test_mid_reset();
        clear_mon();
        cfg_log2_point = 4'd3; cfg_bypass = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 8; k++) push(500 + k);
        for (int k = 0; k < 5; k++) push(600 + k);
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || out_last !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_out: valid=%0b data=%0d last=%0b busy=%0b expected 0 0 0 0",
                     out_valid, out_data, out_last, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ready: in_ready=%0b busy=%0b expected 1 0", in_ready, busy);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) push(700 + k);
        wait_outs(8);
        for (int j = 0; j < 8 && j < out_q.size(); j++) begin
            n_checks++;
            if (out_q[j] !== 64'(700 + br8[j])) begin
                n_fail++;
                $display("FAIL midrst_frame[%0d]: got %0d expected %0d", j, out_q[j], 700 + br8[j]);
            end
        end
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cfg_log2_point = 4'd3;
        cfg_bypass = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_bitrev8();
        test_bypass16();
        test_back_to_back();
        test_backpressure();
        test_cfg_latch();
        test_clamp();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
